dispatch_stage: RTL

DISPATCH_STAGE -- requirements
Module: dispatch_stage

---
 rtl/dispatch_stage_pkg.sv | 46 ++++
 rtl/dispatch_stage_busy_table.sv | 56 +++++
 rtl/dispatch_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/dispatch_stage_pkg.sv
// Shared definitions for the dispatch stage: sizes and the issue-entry field layout.
package dispatch_stage_pkg;

  localparam int PREG_RANGE        = 64;
  localparam int PREG_IDX_W        = $clog2(PREG_RANGE);
  localparam int INSTR_ID_WIDTH    = 7;
  localparam int ISSUE_QUEUE_DEPTH = 16;
  localparam int ENTRY_WIDTH       = 248;

  // Bit positions inside the packed issue entry.
  localparam int ID_MSB          = 247;
  localparam int ID_LSB          = ID_MSB - INSTR_ID_WIDTH + 1;
  localparam int PRD_MSB         = 129;
  localparam int PRD_LSB         = 124;
  localparam int NEED_TO_WB_BIT  = 117;
  localparam int PRS1_MSB        = 116;
  localparam int PRS1_LSB        = 111;
  localparam int PRS2_MSB        = 110;
  localparam int PRS2_LSB        = 105;
  localparam int SRC1_IS_REG_BIT = 104;
  localparam int SRC2_IS_REG_BIT = 103;

  typedef logic [PREG_IDX_W-1:0] preg_idx_t;

  // The subset of entry fields the dispatch stage actually looks at.
  typedef struct packed {
    preg_idx_t prd;
    logic      need_to_wb;
    preg_idx_t prs1;
    preg_idx_t prs2;
    logic      src1_is_reg;
    logic      src2_is_reg;
  } entry_fields_t;

  function automatic entry_fields_t get_fields(input logic [ENTRY_WIDTH-1:0] e);
    entry_fields_t f;
    f.prd         = e[PRD_MSB:PRD_LSB];
    f.need_to_wb  = e[NEED_TO_WB_BIT];
    f.prs1        = e[PRS1_MSB:PRS1_LSB];
    f.prs2        = e[PRS2_MSB:PRS2_LSB];
    f.src1_is_reg = e[SRC1_IS_REG_BIT];
    f.src2_is_reg = e[SRC2_IS_REG_BIT];
    return f;
  endfunction

endpackage

// File: rtl/dispatch_stage_busy_table.sv
// Physical-register busy table: one bit per preg, one set port, two clear ports,
// two read ports. Preg 0 is hardwired not-busy.
module busy_table
  import dispatch_stage_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      set_valid,
  input  preg_idx_t set_idx,
  input  logic      clr_a_valid,
  input  preg_idx_t clr_a_idx,
  input  logic      clr_b_valid,
  input  preg_idx_t clr_b_idx,
  input  preg_idx_t rd_a_idx,
  output logic      rd_a_busy,
  input  preg_idx_t rd_b_idx,
  output logic      rd_b_busy
);

  logic [PREG_RANGE-1:0] busy_reg;
  logic [PREG_RANGE-1:0] busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < PREG_RANGE; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_live
        // Set wins over either clear when both hit this preg in the same cycle.
        always_comb begin
          busy_next[gi] = busy_reg[gi];
          if ((clr_a_valid && clr_a_idx == PREG_IDX_W'(gi)) ||
              (clr_b_valid && clr_b_idx == PREG_IDX_W'(gi)))
            busy_next[gi] = 1'b0;
          if (set_valid && set_idx == PREG_IDX_W'(gi))
            busy_next[gi] = 1'b1;
        end
      end
    end
  endgenerate

  // Busy bit storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      busy_reg <= '0;
    else
      busy_reg <= busy_next;
  end

  // Reads see a same-cycle clear on port a (writeback) so a waking operand is
  // not put to sleep. The set port is not bypassed: it belongs to a younger
  // instruction than the one being read.
  assign rd_a_busy = busy_reg[rd_a_idx] && !(clr_a_valid && clr_a_idx == rd_a_idx);
  assign rd_b_busy = busy_reg[rd_b_idx] && !(clr_a_valid && clr_a_idx == rd_b_idx);

endmodule

// File: rtl/dispatch_stage.sv
// Dispatch stage: single-entry skid register between rename and the issue queue,
// plus busy-table tracking that produces operand sleep bits for the held entry.
module dispatch_stage
  import dispatch_stage_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   rn2disp_valid,
  output logic                   disp2rn_ready,
  input  logic [ENTRY_WIDTH-1:0] rn2disp_data,
  output logic                   disp2isq_valid,
  input  logic                   isq2disp_ready,
  output logic [ENTRY_WIDTH-1:0] disp2isq_wrdata,
  output logic                   disp2isq_rs1_sleepbit,
  output logic                   disp2isq_rs2_sleepbit,
  input  logic                   wb_valid,
  input  logic [5:0]             wb_prd,
  input  logic                   busy_clr_valid,
  input  logic [5:0]             busy_clr_prd,
  input  logic                   flush_valid,
  output logic [31:0]            stall_cnt
);

  logic                   vld_q;
  logic [ENTRY_WIDTH-1:0] data_q;
  logic [31:0]            stall_cnt_reg;
  entry_fields_t          in_f;
  entry_fields_t          held_f;
  logic                   accept;
  logic                   handshake;
  logic                   set_busy;
  logic                   rs1_busy;
  logic                   rs2_busy;

  assign in_f   = get_fields(rn2disp_data);
  assign held_f = get_fields(data_q);

  // Flush blocks both sides for a cycle; otherwise accept whenever the slot
  // is empty or being drained this cycle.
  assign disp2rn_ready   = !flush_valid && (!vld_q || isq2disp_ready);
  assign accept          = rn2disp_valid && disp2rn_ready;
  assign disp2isq_valid  = vld_q && !flush_valid;
  assign handshake       = disp2isq_valid && isq2disp_ready;
  assign disp2isq_wrdata = data_q;
  assign set_busy        = accept && in_f.need_to_wb && (in_f.prd != '0);

  // Slot occupancy: flush empties it, accept refills it (no bubble on a
  // simultaneous drain), a lone drain empties it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      vld_q <= 1'b0;
    else if (flush_valid)
      vld_q <= 1'b0;
    else if (accept)
      vld_q <= 1'b1;
    else if (handshake)
      vld_q <= 1'b0;
  end

  // Entry payload only moves on accept, so it holds steady through a stall.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      data_q <= '0;
    else if (accept)
      data_q <= rn2disp_data;
  end

  // Count cycles an entry is offered but refused, saturating at all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      stall_cnt_reg <= '0;
    else if (vld_q && !isq2disp_ready && !flush_valid && stall_cnt_reg != '1)
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign stall_cnt = stall_cnt_reg;

  busy_table u_busy_table (
    .clock       (clock),
    .reset_n     (reset_n),
    .set_valid   (set_busy),
    .set_idx     (in_f.prd),
    .clr_a_valid (wb_valid),
    .clr_a_idx   (wb_prd),
    .clr_b_valid (busy_clr_valid),
    .clr_b_idx   (busy_clr_prd),
    .rd_a_idx    (held_f.prs1),
    .rd_a_busy   (rs1_busy),
    .rd_b_idx    (held_f.prs2),
    .rd_b_busy   (rs2_busy)
  );

  // Preg 0 reads as not-busy inside the table, so no extra zero check here.
  assign disp2isq_rs1_sleepbit = held_f.src1_is_reg && rs1_busy;
  assign disp2isq_rs2_sleepbit = held_f.src2_is_reg && rs2_busy;

endmodule
